// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, flow-op encodings, PC-unit states and fault codes.
package cpu_pkg;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_EQ     = 3'd1,
        COND_NE     = 3'd2,
        COND_LT     = 3'd3,
        COND_GE     = 3'd4,
        COND_CS     = 3'd5,
        COND_CC     = 3'd6,
        COND_NEVER  = 3'd7
    } cond_e;

    // Codes 5..7 are not listed and decode as NEXT
    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_JMP  = 3'd1,
        OP_CALL = 3'd2,
        OP_RET  = 3'd3,
        OP_HALT = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FAULT_NONE      = 2'd0,
        FAULT_OVERFLOW  = 2'd1,
        FAULT_UNDERFLOW = 2'd2
    } fault_e;

endpackage

// File: rtl/cpu_return_stack.sv
// LIFO of return addresses. Reset clears only the occupancy count; entries are overwritten on push.
module cpu_return_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] top_idx;

    assign wr_idx  = count_q[PTR_W-1:0];
    assign top_idx = count_q[PTR_W-1:0] - PTR_W'(1);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[top_idx];

    always_comb begin
        count_d = count_q;
        if (push_i && !full_o) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop_i && !empty_o) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/cpu_pc_unit.sv
// Program-counter / flow-control unit. Define CPU_CALL_STACK_EN to build in the return stack;
// without it CALL acts as an unconditional jump and RET as NEXT.
module cpu_pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned          PC_WIDTH    = 16,
    parameter int unsigned          STACK_DEPTH = 8,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    input  logic                stall,
    input  logic [2:0]          op,
    input  logic                cond_result,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                taken,
    output logic                halted,
    output logic                fault,
    output logic [1:0]          fault_code
);

    if (STACK_DEPTH < 2 || STACK_DEPTH > 64 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cpu_pc_unit: STACK_DEPTH must be a power of two in 2..64");
    end

    state_e              state_q, state_d;
    fault_e              fault_code_q, fault_code_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                taken_q, taken_d;
    logic                accept;
    logic [PC_WIDTH-1:0] pc_inc;

    assign accept = instr_valid && !stall && (state_q == ST_RUN);
    assign pc_inc = pc_q + PC_WIDTH'(1);

`ifdef CPU_CALL_STACK_EN
    logic                push, pop;
    logic                stk_full, stk_empty;
    logic [PC_WIDTH-1:0] stk_top;

    cpu_return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_inc),
        .data_o  (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            taken_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            taken_q      <= taken_d;
            fault_code_q <= fault_code_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        taken_d      = 1'b0;
        fault_code_d = fault_code_q;
`ifdef CPU_CALL_STACK_EN
        push         = 1'b0;
        pop          = 1'b0;
`endif
        if (accept) begin
            case (op)
                OP_JMP: begin
                    if (cond_result) begin
                        pc_d    = target;
                        taken_d = 1'b1;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                OP_CALL: begin
`ifdef CPU_CALL_STACK_EN
                    if (!stk_full) begin
                        push    = 1'b1;
                        pc_d    = target;
                        taken_d = 1'b1;
                    end else begin
                        state_d      = ST_FAULT;
                        fault_code_d = FAULT_OVERFLOW;
                    end
`else
                    pc_d    = target;
                    taken_d = 1'b1;
`endif
                end
                OP_RET: begin
`ifdef CPU_CALL_STACK_EN
                    if (!stk_empty) begin
                        pop     = 1'b1;
                        pc_d    = stk_top;
                        taken_d = 1'b1;
                    end else begin
                        state_d      = ST_FAULT;
                        fault_code_d = FAULT_UNDERFLOW;
                    end
`else
                    pc_d = pc_inc;
`endif
                end
                OP_HALT: state_d = ST_HALTED;
                default: pc_d = pc_inc;
            endcase
        end
    end

    always_comb begin
        pc         = pc_q;
        taken      = taken_q;
        halted     = (state_q == ST_HALTED);
        fault      = (state_q == ST_FAULT);
        fault_code = fault_code_q;
    end

endmodule

// File: tb/tb_cpu_pc_unit.sv
// Directed self-checking bench for cpu_pc_unit; follows CPU_CALL_STACK_EN to pick expectations.
module tb_cpu_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        cond_result = 1'b0;
    logic [15:0] target = 16'h0;
    logic [15:0] pc;
    logic        taken, halted, fault;
    logic [1:0]  fault_code;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] NEXT = 3'd0, JMP = 3'd1, CALL = 3'd2, RET = 3'd3, HALT = 3'd4;

    cpu_pc_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .stall       (stall),
        .op          (op),
        .cond_result (cond_result),
        .target      (target),
        .pc          (pc),
        .taken       (taken),
        .halted      (halted),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [2:0] o, input logic c,
                        input logic [15:0] t);
        instr_valid = v;
        stall       = s;
        op          = o;
        cond_result = c;
        target      = t;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b1, 1'b0, JMP, 1'b1, 16'h1234);
        rst_n = 1'b1;
    endtask

    task automatic chk_state(input string tag, input logic [15:0] e_pc, input logic e_tk,
                             input logic e_h, input logic e_f, input logic [1:0] e_fc);
        chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
        chk({tag, ".taken"}, 32'(taken), 32'(e_tk));
        chk({tag, ".halted"}, 32'(halted), 32'(e_h));
        chk({tag, ".fault"}, 32'(fault), 32'(e_f));
        chk({tag, ".fcode"}, 32'(fault_code), 32'(e_fc));
    endtask

    initial begin
        // Reset overrides the JMP presented with it
        step(1'b0, 1'b0, NEXT, 1'b0, 16'h0);
        do_reset();
        chk_state("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);

        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0, NEXT, 1'b0, 16'h0);
            chk_state($sformatf("next%0d", i), 16'(i), 1'b0, 1'b0, 1'b0, 2'd0);
        end

        step(1'b1, 1'b0, 3'd6, 1'b1, 16'h0777);
        chk_state("op6_as_next", 16'h0005, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b0, JMP, 1'b1, 16'h0999);
        chk_state("invalid_hold", 16'h0005, 1'b0, 1'b0, 1'b0, 2'd0);

        step(1'b1, 1'b0, JMP, 1'b1, 16'h0010);
        chk_state("jmp_to_10", 16'h0010, 1'b1, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, JMP, 1'b0, 16'h0100);
        chk_state("jmp_nt", 16'h0011, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, JMP, 1'b1, 16'h0100);
        chk_state("jmp_t", 16'h0100, 1'b1, 1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b0, NEXT, 1'b0, 16'h0);
        chk_state("taken_pulse", 16'h0100, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b1, JMP, 1'b1, 16'h0555);
        chk_state("stall_jmp", 16'h0100, 1'b0, 1'b0, 1'b0, 2'd0);

        step(1'b1, 1'b0, JMP, 1'b1, 16'h0020);
        step(1'b1, 1'b0, CALL, 1'b0, 16'h0200);
        chk_state("call_200", 16'h0200, 1'b1, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, RET, 1'b0, 16'h0);
`ifdef CPU_CALL_STACK_EN
        chk_state("ret", 16'h0021, 1'b1, 1'b0, 1'b0, 2'd0);
`else
        chk_state("ret_as_next", 16'h0201, 1'b0, 1'b0, 1'b0, 2'd0);
`endif

        step(1'b1, 1'b0, JMP, 1'b1, 16'hFFFF);
        step(1'b1, 1'b0, NEXT, 1'b0, 16'h0);
        chk_state("wrap", 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);

        // RET with nothing pushed
        do_reset();
        step(1'b1, 1'b1, RET, 1'b0, 16'h0);
        chk_state("stall_ret_empty", 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, RET, 1'b0, 16'h0);
`ifdef CPU_CALL_STACK_EN
        chk_state("ret_underflow", 16'h0000, 1'b0, 1'b0, 1'b1, 2'd2);
        step(1'b1, 1'b0, JMP, 1'b1, 16'h0300);
        chk_state("fault_frozen", 16'h0000, 1'b0, 1'b0, 1'b1, 2'd2);
`else
        chk_state("ret_no_stack", 16'h0001, 1'b0, 1'b0, 1'b0, 2'd0);
`endif

        // Eight nested CALLs fill the stack; the ninth overflows when the stack is built in
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, CALL, 1'b0, 16'h0100 + 16'(i));
            chk_state($sformatf("call%0d", i), 16'h0100 + 16'(i), 1'b1, 1'b0, 1'b0, 2'd0);
        end
        step(1'b1, 1'b1, CALL, 1'b0, 16'h0400);
        chk_state("stall_call_full", 16'h0107, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, CALL, 1'b0, 16'h0400);
`ifdef CPU_CALL_STACK_EN
        chk_state("call_overflow", 16'h0107, 1'b0, 1'b0, 1'b1, 2'd1);
`else
        chk_state("call9_as_jmp", 16'h0400, 1'b1, 1'b0, 1'b0, 2'd0);
`endif
        do_reset();
        chk_state("reset_clears_fault", 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, RET, 1'b0, 16'h0);
`ifdef CPU_CALL_STACK_EN
        chk_state("stack_discarded", 16'h0000, 1'b0, 1'b0, 1'b1, 2'd2);
`else
        chk_state("stack_discarded", 16'h0001, 1'b0, 1'b0, 1'b0, 2'd0);
`endif

        // Two nested calls unwind in LIFO order
        do_reset();
        step(1'b1, 1'b0, CALL, 1'b0, 16'h0040);
        step(1'b1, 1'b0, CALL, 1'b0, 16'h0080);
        step(1'b1, 1'b0, RET, 1'b0, 16'h0);
`ifdef CPU_CALL_STACK_EN
        chk_state("lifo_ret1", 16'h0041, 1'b1, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, RET, 1'b0, 16'h0);
        chk_state("lifo_ret2", 16'h0001, 1'b1, 1'b0, 1'b0, 2'd0);
`else
        chk_state("lifo_ret1", 16'h0081, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, RET, 1'b0, 16'h0);
        chk_state("lifo_ret2", 16'h0082, 1'b0, 1'b0, 1'b0, 2'd0);
`endif

        do_reset();
        step(1'b1, 1'b0, JMP, 1'b1, 16'h0050);
        step(1'b1, 1'b1, HALT, 1'b0, 16'h0);
        chk_state("stall_halt", 16'h0050, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, HALT, 1'b0, 16'h0);
        chk_state("halt", 16'h0050, 1'b0, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, NEXT, 1'b0, 16'h0);
            chk_state($sformatf("halt_frozen%0d", i), 16'h0050, 1'b0, 1'b1, 1'b0, 2'd0);
        end
        do_reset();
        chk_state("reset_from_halt", 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_pc_unit.md
CPU_PC_UNIT -- requirements
Module: cpu_pc_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk (all state updates on rising edge) and rst_n (reset applies when sampled low at a rising edge).
REQ-002 Parameter PC_WIDTH, default 16: width of the program counter and of jump targets.
REQ-003 Parameter STACK_DEPTH, default 8: number of return-address entries (power of two, 2..64).
REQ-004 Parameter RESET_PC, default 0: PC value loaded by reset.
REQ-005 Port clk  input  1  system clock.
REQ-006 Port rst_n  input  1  synchronous active-low reset.
REQ-007 Port instr_valid  input  1  current instruction is valid and its op is to be executed.
REQ-008 Port stall  input  1  hold all state this cycle; overrides instr_valid.
REQ-009 Port op  input  3  flow op: NEXT=0, JMP=1, CALL=2, RET=3, HALT=4; codes 5..7 are treated as NEXT.
REQ-010 Port cond_result  input  1  jump-condition decoder result, used only by JMP.
REQ-011 Port target  input  PC_WIDTH  destination address for JMP and CALL.
REQ-012 Port pc  output  PC_WIDTH  current program counter (registered).
REQ-013 Port taken  output  1  one-cycle pulse: the previous accepted op redirected the PC.
REQ-014 Port halted  output  1  block is in state HALTED.
REQ-015 Port fault  output  1  block is in state FAULT.
REQ-016 Port fault_code  output  2  0 none, 1 stack overflow, 2 stack underflow; held while in FAULT.

Function
REQ-017 An op SHALL be accepted on a rising edge where instr_valid=1, stall=0 and state=RUN; otherwise pc, the stack and state SHALL hold and taken SHALL be 0 in the following cycle.
REQ-018 States SHALL be RUN, HALTED and FAULT; HALTED and FAULT SHALL be left only by reset.
REQ-019 NEXT: pc <= pc+1 modulo 2^PC_WIDTH (all-ones wraps to 0); taken <= 0.
REQ-020 JMP: if cond_result=1 then pc <= target and taken <= 1, else pc <= pc+1 and taken <= 0.
REQ-021 CALL: if the stack is not full, push pc+1 (wrapped), pc <= target, taken <= 1; if full, no push, pc holds, state <= FAULT, fault_code <= 1.
REQ-022 RET: if the stack is not empty, pop and pc <= popped value, taken <= 1; if empty, pc holds, state <= FAULT, fault_code <= 2.
REQ-023 HALT: pc holds, state <= HALTED, taken <= 0.
REQ-024 Latency: a new pc value SHALL be visible on the cycle after the accepting edge; no combinational path from any input to pc, taken, halted, fault or fault_code.
REQ-025 A CALL into a stack holding STACK_DEPTH-1 entries SHALL succeed, leaving the stack full; the next CALL SHALL fault.
REQ-026 Stall asserted together with any op, including HALT, CALL into a full stack or RET from an empty stack, SHALL have no effect.

Reset
REQ-027 Reset SHALL set pc=RESET_PC, state=RUN, stack pointer=0 (empty), taken=0, halted=0, fault=0 and fault_code=0, and SHALL override any op presented in the same cycle.
REQ-028 Reset mid-operation, from any state, SHALL discard all stack contents.

Configuration
REQ-029 With macro CPU_CALL_STACK_EN defined, the return stack and the CALL/RET behaviour above SHALL be compiled in.
REQ-030 Without CPU_CALL_STACK_EN, no stack storage SHALL exist, CALL SHALL behave as unconditional JMP (pc <= target, taken <= 1), RET SHALL behave as NEXT, and fault_code 1 and 2 SHALL never occur.

Structure
REQ-031 The op encodings, state encodings and fault codes SHALL be defined once in the shared cpu_pkg package, alongside the existing condition codes.
REQ-032 The return stack SHALL be a sub-module, cpu_return_stack, with push, pop, full and empty signals, instantiated only under CPU_CALL_STACK_EN.

Verification
REQ-033 Reset then four NEXT ops -> pc sequence 0,1,2,3,4; taken=0 throughout.
REQ-034 pc=0x0010: JMP with target=0x0100 and cond_result=0 -> pc=0x0011, taken=0; JMP with cond_result=1 -> pc=0x0100, taken=1 for exactly one cycle.
REQ-035 pc=0x0020: CALL to 0x0200, then RET -> pc=0x0200, then pc=0x0021; with CPU_CALL_STACK_EN undefined, the same RET gives pc=0x0201.
REQ-036 Eight nested CALLs succeed; the ninth -> fault=1, fault_code=1, pc unchanged; reset -> fault=0, pc=0.
REQ-037 RET after reset -> fault_code=2; separately, pc=0xFFFF with NEXT -> pc=0x0000.
REQ-038 HALT with stall=1 -> no change; HALT with stall=0 -> halted=1, and later NEXT ops leave pc frozen.
